// File: rtl/ram_arbiter_if.sv
`timescale 1ns/1ps
// Client-side bundle for ram_arbiter: two req/gnt command ports plus shared read-data return.
// master = the two client blocks, slave = the arbiter.
interface ram_arbiter_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
);
    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              gnt_a;
    logic              rvalid_a;

    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              gnt_b;
    logic              rvalid_b;

    logic [DATA_W-1:0] rdata;

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        input  gnt_a, rvalid_a, gnt_b, rvalid_b, rdata
    );

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        output gnt_a, rvalid_a, gnt_b, rvalid_b, rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
`timescale 1ns/1ps
// ram_arbiter: two-port req/gnt arbiter that sequences one access per two cycles into a
// single-port synchronous RAM. Build option RAM_ARB_FIXED_PRIO_EN: port A always wins ties.
module ram_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_arbiter_if.slave      bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_datain,
    output logic              ram_read,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_dataout
);

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

    state_e            state_q,      state_d;
    logic              owner_q,      owner_d;
    logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
    logic [DATA_W-1:0] ram_datain_q, ram_datain_d;
    logic              ram_read_q,   ram_read_d;
    logic              ram_write_q,  ram_write_d;
    logic              gnt_a_q,      gnt_a_d;
    logic              gnt_b_q,      gnt_b_d;
    logic              rvalid_a_q,   rvalid_a_d;
    logic              rvalid_b_q,   rvalid_b_d;

    logic any_req;
    logic win_b;
    logic win_we;

    assign any_req = bus.req_a | bus.req_b;

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Port B only wins when A is not asking.
    assign win_b = ~bus.req_a;
`else
    logic ptr_q, ptr_d;

    // Round-robin: on a tie the pointer names the winner; it moves to the loser after ISSUE.
    assign win_b = bus.req_b & (~bus.req_a | (ptr_q == PORT_B));

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_ISSUE) begin
            ptr_d = ~owner_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PORT_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign win_we = win_b ? bus.we_b : bus.we_a;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        ram_addr_d   = ram_addr_q;
        ram_datain_d = ram_datain_q;
        ram_read_d   = 1'b0;
        ram_write_d  = 1'b0;
        gnt_a_d      = 1'b0;
        gnt_b_d      = 1'b0;
        rvalid_a_d   = 1'b0;
        rvalid_b_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d      = S_ISSUE;
                    owner_d      = win_b ? PORT_B : PORT_A;
                    ram_addr_d   = win_b ? bus.addr_b  : bus.addr_a;
                    ram_datain_d = win_b ? bus.wdata_b : bus.wdata_a;
                    ram_write_d  = win_we;
                    ram_read_d   = ~win_we;
                    gnt_a_d      = ~win_b;
                    gnt_b_d      = win_b;
                end
            end
            S_ISSUE: begin
                // The RAM captures the read on this edge; its output is valid next cycle.
                state_d    = S_IDLE;
                rvalid_a_d = ram_read_q & (owner_q == PORT_A);
                rvalid_b_d = ram_read_q & (owner_q == PORT_B);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= PORT_A;
            ram_addr_q   <= '0;
            ram_datain_q <= '0;
            ram_read_q   <= 1'b0;
            ram_write_q  <= 1'b0;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            rvalid_a_q   <= 1'b0;
            rvalid_b_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            ram_addr_q   <= ram_addr_d;
            ram_datain_q <= ram_datain_d;
            ram_read_q   <= ram_read_d;
            ram_write_q  <= ram_write_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            rvalid_a_q   <= rvalid_a_d;
            rvalid_b_q   <= rvalid_b_d;
        end
    end

    assign ram_addr     = ram_addr_q;
    assign ram_datain   = ram_datain_q;
    assign ram_read     = ram_read_q;
    assign ram_write    = ram_write_q;
    assign bus.gnt_a    = gnt_a_q;
    assign bus.gnt_b    = gnt_b_q;
    assign bus.rvalid_a = rvalid_a_q;
    assign bus.rvalid_b = rvalid_b_q;

    // The RAM output register is the read pipeline stage; zero it outside the valid cycle.
    assign bus.rdata = (rvalid_a_q | rvalid_b_q) ? ram_dataout : DATA_W'(0);

    a_gnt_onehot    : assert property (@(posedge clk) disable iff (!rst_n) !(gnt_a_q && gnt_b_q));
    a_rvalid_onehot : assert property (@(posedge clk) disable iff (!rst_n) !(rvalid_a_q && rvalid_b_q));
    a_strobe_onehot : assert property (@(posedge clk) disable iff (!rst_n) !(ram_read_q && ram_write_q));

endmodule
